bcd_clock_editor: RTL and testbench
===================================

# bcd_clock_editor

Time-of-day controller that sequences the six-digit seven-segment display driver. It keeps a BCD HH:MM:SS count and supplies the driver's `enable`, `twinkle` and `number_BCD` inputs. It also runs an edit mode in which one digit blinks and user keys set the time. It sits between the debounced key block and the display driver.

## Interface
- `TICK_CNT`, default 50_000_000: clk cycles per second of time.
- `BLANK_LZ`, default 0: 1 = blank the hour-tens digit when it is 0.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_mode`  in  1  one-cycle pulse; toggles between RUN and EDIT.
- `key_next`  in  1  one-cycle pulse; in EDIT, moves the selection one digit left.
- `key_inc`  in  1  one-cycle pulse; in EDIT, increments the selected digit.
- `enable`  out  6  per-digit enable to the display driver.
- `twinkle`  out  6  one-hot blink select to the display driver; 0 in RUN.
- `number_BCD`  out  24  digit k occupies bits [4k+3:4k].
  - Digit 0 = seconds units … digit 5 = hours tens.
- `sec_pulse`  out  1  one-cycle pulse on each one-second tick in RUN.
- `edit_mode`  out  1  1 while in EDIT.

## Operation
- States: RUN and EDIT. Reset enters RUN.
- `key_mode` in RUN:
  - go to EDIT, set `sel` = 0, clear the prescaler.
- `key_mode` in EDIT:
  - go to RUN, clear the prescaler.
- RUN:
  - The prescaler counts 0..TICK_CNT-1.
  - At TICK_CNT-1 it wraps to 0, pulses `sec_pulse` and increments the time by one second.
  - Carry chain: 9→0 on units digits, 5→0 on minute/second tens.
  - 23:59:59 wraps to 00:00:00.
- EDIT:
  - Time is frozen and the prescaler is held at 0.
  - `key_inc` increments digit `sel` modulo its limit, with no carry into other digits:
    - Limits: s-units 9, s-tens 5, m-units 9, m-tens 5, h-tens 2.
    - h-units limit is 3 if h-tens = 2, otherwise 9.
  - When h-tens steps to 2 while h-units > 3, h-units is forced to 3 in the same cycle.
  - `key_next` sets `sel` = (sel = 5) ? 0 : sel+1.
- Key priority within one cycle:
  - `key_mode` overrides `key_next`/`key_inc`.
  - `key_inc` and `key_next` together: increment the old `sel`, then advance `sel`.
- Keys with no effect in the current state are ignored: `key_next`/`key_inc` in RUN.
- Outputs:
  - `twinkle` = one-hot(sel) in EDIT, 0 in RUN.
  - `enable` = 6'h3F, except bit 5 = 0 when BLANK_LZ=1 and h-tens = 0 and state = RUN.
  - In EDIT, all digits stay enabled.

## Timing
- Reset values:
  - time 00:00:00, `number_BCD` = 24'h000000;
  - `enable` = 6'h3F (bit 5 = 0 if BLANK_LZ=1);
  - `twinkle` = 0, `sec_pulse` = 0, `edit_mode` = 0, `sel` = 0, prescaler = 0.
- All outputs are registered. A key pulse at edge n is visible on the outputs after edge n+1.
- First `sec_pulse` after reset or after leaving EDIT: TICK_CNT cycles after that edge. Period thereafter is exactly TICK_CNT.
- The time update and `sec_pulse` appear in the same cycle.
- `rst` mid-EDIT returns to RUN at 00:00:00 on the same edge and discards any key pulse in that cycle.
- TICK_CNT ≥ 2. The prescaler width is clog2(TICK_CNT).

## Structure
- Package `clock_editor_pkg`:
  - state enum;
  - digit index constants DIG_SU..DIG_HT;
  - per-digit limit constants;
  - the h-units limit rule.
- Sub-module `bcd_time_counter`:
  - holds the six digits;
  - inputs: tick, edit-increment, digit select;
  - applies the carry chain and the limit/clamp rules.
- The top level holds the prescaler, the state machine, `sel`, and the output registers.

## Test plan
1. Reset with TICK_CNT=4:
   - outputs match the reset values;
   - `sec_pulse` first appears 4 cycles after reset release, then every 4 cycles;
   - `number_BCD` counts 000001, 000002, …
2. Preload 23:59:58 via EDIT, return to RUN, wait two ticks:
   - `number_BCD` 235959 then 000000;
   - no intermediate illegal values.
3. In EDIT, `sel` = 5:
   - from 19:xx:xx, `key_inc` → 29 clamps to 23;
   - `key_inc` again → 03.
4. EDIT with six `key_next` pulses: `twinkle` 000010, 000100, 001000, 010000, 100000, 000001.
5. `key_mode`+`key_inc` in the same cycle while in EDIT:
   - state RUN, digit unchanged, `twinkle` = 0.
   - `key_inc`+`key_next` together at sel 0 on digit value 9: digit 0 → 0, sel → 1.
6. Assert `rst` during EDIT with a time of 12:34:56:
   - next cycle: `edit_mode` 0, `number_BCD` 000000, `twinkle` 0.
   - BLANK_LZ=1: `enable` = 6'h1F in RUN.

Source files
------------

// File: rtl/clock_editor_pkg.sv
// Shared types and digit rules for the BCD time-of-day editor.
// Digit indices run from seconds units (0) up to hours tens (5).
package clock_editor_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  localparam logic [2:0] DIG_SU = 3'd0;
  localparam logic [2:0] DIG_ST = 3'd1;
  localparam logic [2:0] DIG_MU = 3'd2;
  localparam logic [2:0] DIG_MT = 3'd3;
  localparam logic [2:0] DIG_HU = 3'd4;
  localparam logic [2:0] DIG_HT = 3'd5;

  localparam logic [3:0] LIM_SU     = 4'd9;
  localparam logic [3:0] LIM_ST     = 4'd5;
  localparam logic [3:0] LIM_MU     = 4'd9;
  localparam logic [3:0] LIM_MT     = 4'd5;
  localparam logic [3:0] LIM_HT     = 4'd2;
  localparam logic [3:0] LIM_HU_MAX = 4'd9;
  localparam logic [3:0] LIM_HU_23  = 4'd3;

  // Hours units may only reach 3 once hours tens is 2 (caps the day at 23).
  function automatic logic [3:0] hu_limit(input logic [3:0] ht);
    return (ht == LIM_HT) ? LIM_HU_23 : LIM_HU_MAX;
  endfunction

  function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] ht);
    logic [3:0] lim;
    lim = LIM_SU;
    case (idx)
      DIG_SU:  lim = LIM_SU;
      DIG_ST:  lim = LIM_ST;
      DIG_MU:  lim = LIM_MU;
      DIG_MT:  lim = LIM_MT;
      DIG_HU:  lim = hu_limit(ht);
      DIG_HT:  lim = LIM_HT;
      default: lim = LIM_SU;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Six-digit BCD HH:MM:SS store: one-second carry chain in RUN,
// single-digit wrap-around increment (no carry) in EDIT.
module bcd_time_counter
  import clock_editor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        inc,
  input  logic [2:0]  sel,
  output logic [23:0] time_bcd,
  output logic [3:0]  ht_next
);

  logic [3:0] digit_reg  [6];
  logic [3:0] digit_next [6];
  logic [3:0] lim;

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      digit_next[k] = digit_reg[k];
    end
    lim = LIM_SU;

    if (tick) begin
      if (digit_reg[DIG_SU] != LIM_SU) begin
        digit_next[DIG_SU] = digit_reg[DIG_SU] + 4'd1;
      end else begin
        digit_next[DIG_SU] = 4'd0;
        if (digit_reg[DIG_ST] != LIM_ST) begin
          digit_next[DIG_ST] = digit_reg[DIG_ST] + 4'd1;
        end else begin
          digit_next[DIG_ST] = 4'd0;
          if (digit_reg[DIG_MU] != LIM_MU) begin
            digit_next[DIG_MU] = digit_reg[DIG_MU] + 4'd1;
          end else begin
            digit_next[DIG_MU] = 4'd0;
            if (digit_reg[DIG_MT] != LIM_MT) begin
              digit_next[DIG_MT] = digit_reg[DIG_MT] + 4'd1;
            end else begin
              digit_next[DIG_MT] = 4'd0;
              // 23 rolls to 00; otherwise hours count as a plain two-digit BCD value
              if (digit_reg[DIG_HT] == LIM_HT && digit_reg[DIG_HU] == LIM_HU_23) begin
                digit_next[DIG_HU] = 4'd0;
                digit_next[DIG_HT] = 4'd0;
              end else if (digit_reg[DIG_HU] == LIM_HU_MAX) begin
                digit_next[DIG_HU] = 4'd0;
                digit_next[DIG_HT] = digit_reg[DIG_HT] + 4'd1;
              end else begin
                digit_next[DIG_HU] = digit_reg[DIG_HU] + 4'd1;
              end
            end
          end
        end
      end
    end else if (inc && sel <= DIG_HT) begin
      lim = digit_limit(sel, digit_reg[DIG_HT]);
      digit_next[sel] = (digit_reg[sel] >= lim) ? 4'd0 : digit_reg[sel] + 4'd1;
      if (sel == DIG_HT && digit_next[DIG_HT] == LIM_HT && digit_reg[DIG_HU] > LIM_HU_23) begin
        digit_next[DIG_HU] = LIM_HU_23;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) begin
        digit_reg[k] <= 4'd0;
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        digit_reg[k] <= digit_next[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_pack
      assign time_bcd[4*gi +: 4] = digit_reg[gi];
    end
  endgenerate

  assign ht_next = digit_next[DIG_HT];

endmodule

// File: rtl/bcd_clock_editor.sv
// Time-of-day controller feeding the six-digit display driver:
// prescaler, RUN/EDIT state machine, digit selection and registered outputs.
module bcd_clock_editor
  import clock_editor_pkg::*;
#(
  parameter int TICK_CNT = 50_000_000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_next,
  input  logic        key_inc,
  output logic [5:0]  enable,
  output logic [5:0]  twinkle,
  output logic [23:0] number_BCD,
  output logic        sec_pulse,
  output logic        edit_mode
);

  localparam int PW = $clog2(TICK_CNT);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CNT - 1);
  localparam logic [5:0] ENABLE_RST = BLANK_LZ ? 6'h1F : 6'h3F;

  state_t        state_reg, state_next;
  logic [2:0]    sel_reg, sel_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          tick, inc_en;
  logic [3:0]    ht_next;
  logic [5:0]    twinkle_reg, twinkle_next;
  logic [5:0]    enable_reg, enable_next;
  logic          sec_pulse_reg;
  logic          edit_mode_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      sel_reg   <= DIG_SU;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      presc_reg <= presc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    presc_next = presc_reg;
    tick       = 1'b0;
    inc_en     = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (key_mode) begin
          state_next = ST_EDIT;
          sel_next   = DIG_SU;
          presc_next = '0;
        end else if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          tick       = 1'b1;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      ST_EDIT: begin
        presc_next = '0;
        if (key_mode) begin
          state_next = ST_RUN;
        end else begin
          // Increment acts on the old selection even when next arrives together
          inc_en = key_inc;
          if (key_next) begin
            sel_next = (sel_reg == DIG_HT) ? DIG_SU : sel_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  bcd_time_counter u_time (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .inc      (inc_en),
    .sel      (sel_reg),
    .time_bcd (number_BCD),
    .ht_next  (ht_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_twinkle
      assign twinkle_next[gi] = (state_next == ST_EDIT) && (sel_next == 3'(gi));
    end
  endgenerate

  assign enable_next = {~(BLANK_LZ && state_next == ST_RUN && ht_next == 4'd0), 5'h1F};

  always_ff @(posedge clk) begin
    if (rst) begin
      twinkle_reg   <= 6'h00;
      enable_reg    <= ENABLE_RST;
      sec_pulse_reg <= 1'b0;
      edit_mode_reg <= 1'b0;
    end else begin
      twinkle_reg   <= twinkle_next;
      enable_reg    <= enable_next;
      sec_pulse_reg <= tick;
      edit_mode_reg <= (state_next == ST_EDIT);
    end
  end

  assign twinkle   = twinkle_reg;
  assign enable    = enable_reg;
  assign sec_pulse = sec_pulse_reg;
  assign edit_mode = edit_mode_reg;

endmodule

// File: tb/tb_bcd_clock_editor.sv
// Randomized and directed bench for bcd_clock_editor against a seconds-of-day
// reference model; two instances cover both leading-zero blanking settings.
module tb_bcd_clock_editor;

  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_mode = 1'b0, key_next = 1'b0, key_inc = 1'b0;
  logic [5:0]  enable0, twinkle0, enable1, twinkle1;
  logic [23:0] bcd0, bcd1;
  logic        sp0, sp1, em0, em1;

  int n_checks = 0;
  int n_fail   = 0;

  int m_secs  = 0;
  int m_sel   = 0;
  int m_presc = 0;
  bit m_edit  = 1'b0;
  bit m_pulse = 1'b0;

  always #5 clk = ~clk;

  bcd_clock_editor #(.TICK_CNT(TC), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
    .enable(enable0), .twinkle(twinkle0), .number_BCD(bcd0), .sec_pulse(sp0), .edit_mode(em0)
  );

  bcd_clock_editor #(.TICK_CNT(TC), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
    .enable(enable1), .twinkle(twinkle1), .number_BCD(bcd1), .sec_pulse(sp1), .edit_mode(em1)
  );

  function automatic int dig(input int secs, input int k);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    case (k)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      3: return m / 10;
      4: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  function automatic logic [23:0] bcd_of(input int secs);
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v[4*k +: 4] = 4'(dig(secs, k));
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  // Edit increment on the model: one digit wraps at its limit, hours clamp to 23.
  task automatic model_inc();
    int d[6];
    int lim;
    for (int k = 0; k < 6; k++) d[k] = dig(m_secs, k);
    case (m_sel)
      0, 2:    lim = 9;
      1, 3:    lim = 5;
      4:       lim = (d[5] == 2) ? 3 : 9;
      default: lim = 2;
    endcase
    d[m_sel] = (d[m_sel] >= lim) ? 0 : d[m_sel] + 1;
    if (m_sel == 5 && d[5] == 2 && d[4] > 3) d[4] = 3;
    m_secs = (d[5]*10 + d[4])*3600 + (d[3]*10 + d[2])*60 + d[1]*10 + d[0];
  endtask

  task automatic model_edge(input logic r, input logic m, input logic n, input logic i);
    m_pulse = 1'b0;
    if (r) begin
      m_secs = 0; m_edit = 1'b0; m_sel = 0; m_presc = 0;
    end else if (m) begin
      m_presc = 0;
      if (!m_edit) begin
        m_edit = 1'b1; m_sel = 0;
      end else begin
        m_edit = 1'b0;
      end
    end else if (m_edit) begin
      if (i) model_inc();
      if (n) m_sel = (m_sel + 1) % 6;
    end else if (m_presc == TC - 1) begin
      m_presc = 0;
      m_pulse = 1'b1;
      m_secs  = (m_secs + 1) % 86400;
    end else begin
      m_presc++;
    end
  endtask

  task automatic check_outputs();
    check_val("number_BCD", 32'(bcd0), 32'(bcd_of(m_secs)));
    check_val("twinkle", 32'(twinkle0), m_edit ? 32'(1 << m_sel) : 32'h0);
    check_val("enable", 32'(enable0), 32'h3F);
    check_val("enable_blank", 32'(enable1), (!m_edit && dig(m_secs, 5) == 0) ? 32'h1F : 32'h3F);
    check_val("sec_pulse", 32'(sp0), 32'(m_pulse));
    check_val("edit_mode", 32'(em0), 32'(m_edit));
  endtask

  task automatic step(input logic r, input logic m, input logic n, input logic i);
    rst = r; key_mode = m; key_next = n; key_inc = i;
    @(posedge clk);
    model_edge(r, m, n, i);
    #1;
    rst = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
    check_outputs();
    if (r || m || n || i)
      $display("t=%0t rst=%0b mode=%0b next=%0b inc=%0b -> bcd=%h twinkle=%b edit=%0b",
               $time, r, m, n, i, bcd0, twinkle0, em0);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto_sel(input int k);
    for (int t = 0; t < 6 && m_sel != k; t++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Two passes let hours units reach values above 3 after hours tens leaves 2.
  task automatic set_time(input logic [23:0] target);
    if (!m_edit) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 6; k++) begin
        goto_sel(k);
        for (int t = 0; t < 10 && dig(m_secs, k) != int'(target[4*k +: 4]); t++)
          step(1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    // Reset values and first seconds after release
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_val("no_pulse_before_4", 32'(sp0), 32'h0);
    idle(1);
    check_val("first_pulse_at_4", 32'(sp0), 32'h1);
    check_val("first_second", 32'(bcd0), 32'h000001);
    idle(12);

    // Preload 23:59:58 and roll over midnight
    set_time(24'h235958);
    check_val("preload", 32'(bcd0), 32'h235958);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_val("at_235959", 32'(bcd0), 32'h235959);
    idle(4);
    check_val("midnight", 32'(bcd0), 32'h000000);
    idle(3);

    // Hours tens clamp: 19 -> 23 -> 03
    set_time(24'h190000);
    goto_sel(5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("clamp_23", 32'(bcd0[23:16]), 32'h23);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("wrap_03", 32'(bcd0[23:16]), 32'h03);

    // Selection walk with six next pulses
    goto_sel(0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("walk_back_to_0", 32'(twinkle0), 32'h01);

    // Mode overrides inc
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("mode_over_inc", 32'(em0), 32'h0);

    // inc+next at sel 0 on a 9
    set_time(24'h000009);
    goto_sel(0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("inc_next_digit", 32'(bcd0[3:0]), 32'h0);
    check_val("inc_next_sel", 32'(twinkle0), 32'h02);

    // Reset mid-EDIT with a key pulse in the same cycle
    set_time(24'h123456);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("rst_edit_mode", 32'(em0), 32'h0);
    check_val("rst_bcd", 32'(bcd0), 32'h000000);
    check_val("rst_enable_blank", 32'(enable1), 32'h1F);
    idle(5);

    // Randomized key traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
